alu32: RTL and testbench
========================

# alu32

32-bit combinational integer ALU for the single-cycle/multicycle processor datapath; the execute stage drives two operands and a 3-bit control code and consumes the result in the same cycle. A small set of condition flags (zero, negative, carry, overflow) is registered on the clock for later use by branch/compare logic. Only the flag register uses the clock and reset.

## Interface
- Parameters: none (width fixed at 32 via package constant `ALU_W`).
- `clk`  in  1  clock; flags update on rising edge.
- `reset`  in  1  synchronous, active-low; clears flag register.
- `a`  in  32  operand A.
- `b`  in  32  operand B.
- `alu_control`  in  3  operation select.
- `result`  out  32  combinational result.
- `flags`  out  4  registered {zero, negative, carry, overflow} of the previous cycle's operation.

## Operation
- `alu_control` encoding:
  - 000 AND: a & b
  - 001 OR: a | b
  - 010 ADD: a + b (mod 2^32)
  - 011 reserved: result = 0 (see Configuration)
  - 100 AND-NOT: a & ~b
  - 101 OR-NOT: a | ~b
  - 110 SUB: a − b, computed as a + ~b + 1
  - 111 SLT: result = 32'd1 if a < b signed, else 0; computed as sign(a−b) XOR overflow(a−b)
- Single shared adder: second operand is b or ~b, carry-in = `alu_control[2]`.
- Carry = carry-out of the adder (SUB: 1 means no borrow). Overflow = operands of same effective sign, sum of different sign.
- Flag next-state: zero = (result == 0); negative = result[31]; carry/overflow = adder outputs for ADD, SUB, SLT (and SLTU if compiled); 0 for logic ops and reserved code.
- Unknown/X on inputs is not handled; no internal state besides flags.

## Timing
- `result`: purely combinational, zero latency; valid within the same cycle as input change; unaffected by `reset`.
- `flags`: one-cycle latency; captured at every rising `clk` from the current inputs' next-state value; no enable.
- Reset: when `reset` == 0 at a rising edge, `flags` ← 4'b0000. Reset dominates any capture in that cycle. Reset mid-operation does not disturb `result`.
- Flags reset value 0 after power-up only once first reset edge occurs; before that undefined.

## Configuration
- `ALU_SLTU_EN` defined: code 011 = SLTU, result = 32'd1 if a < b unsigned (adder carry-out of a−b is 0), else 0; flags take adder carry/overflow.
- Not defined: code 011 yields result = 0 and carry = overflow = 0, zero flag = 1.

## Structure
- Package `alu_pkg`: `ALU_W = 32`; enum `alu_op_e` (ALU_AND, ALU_OR, ALU_ADD, ALU_RSVD/ALU_SLTU, ALU_ANDN, ALU_ORN, ALU_SUB, ALU_SLT); flag bit index constants `FLG_Z, FLG_N, FLG_C, FLG_V`.
- Sub-module `alu_adder`: 32-bit adder, inputs x, y, cin; outputs sum, cout, ovf. Top holds operand inversion, result mux, flag register.

## Test plan
- ADD: a=0x7FFF_FFFF, b=1, ctl=010 -> result 0x8000_0000; next cycle flags N=1, V=1, C=0, Z=0.
- SUB: a=5, b=5, ctl=110 -> result 0; flags Z=1, C=1, V=0; a=0, b=1 -> 0xFFFF_FFFF, C=0, N=1.
- Logic: a=0xF0F0_F0F0, b=0xFF00_FF00 -> 000: 0xF000_F000; 001: 0xFFF0_FFF0; 100: 0x00F0_00F0; 101: 0xF0FF_F0FF.
- SLT: a=0x8000_0000, b=1, ctl=111 -> 1; a=0x7FFF_FFFF, b=0x8000_0000 -> 0 (overflow case correct).
- Code 011: a=1, b=2 -> 0 without `ALU_SLTU_EN`; with it -> 1, and a=0xFFFF_FFFF, b=1 -> 0.
- Reset: drive ADD of 0xFFFF_FFFF+1 with reset=0 at an edge -> flags 0000 while result = 0; release reset -> next edge flags Z=1, C=1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared constants and types for the alu32 datapath block.
// ALU_SLTU_EN selects whether code 3'b011 is an unsigned set-less-than.
package alu_pkg;

  localparam int ALU_W = 32;

  // Bit positions inside the 4-bit flags vector {zero, negative, carry, overflow}.
  localparam int FLG_Z = 3;
  localparam int FLG_N = 2;
  localparam int FLG_C = 1;
  localparam int FLG_V = 0;

  typedef enum logic [2:0] {
    ALU_AND  = 3'b000,
    ALU_OR   = 3'b001,
    ALU_ADD  = 3'b010,
`ifdef ALU_SLTU_EN
    ALU_SLTU = 3'b011,
`else
    ALU_RSVD = 3'b011,
`endif
    ALU_ANDN = 3'b100,
    ALU_ORN  = 3'b101,
    ALU_SUB  = 3'b110,
    ALU_SLT  = 3'b111
  } alu_op_e;

  // True for operations whose carry/overflow flags come from the adder.
  function automatic logic is_arith(input alu_op_e op);
    case (op)
      ALU_ADD, ALU_SUB, ALU_SLT: is_arith = 1'b1;
`ifdef ALU_SLTU_EN
      ALU_SLTU:                  is_arith = 1'b1;
`endif
      default:                   is_arith = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_adder.sv
// Single shared two's-complement adder used for ADD, SUB and the compares.
// Overflow is reported for signed interpretation of x and y.
module alu_adder
  import alu_pkg::*;
(
  input  logic [ALU_W-1:0] x,
  input  logic [ALU_W-1:0] y,
  input  logic             cin,
  output logic [ALU_W-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  logic [ALU_W:0] full_sum;

  assign full_sum = {1'b0, x} + {1'b0, y} + {{ALU_W{1'b0}}, cin};
  assign sum      = full_sum[ALU_W-1:0];
  assign cout     = full_sum[ALU_W];
  // Same-sign operands producing a differently-signed sum.
  assign ovf      = (x[ALU_W-1] == y[ALU_W-1]) && (sum[ALU_W-1] != x[ALU_W-1]);

endmodule

// File: rtl/alu32.sv
// 32-bit combinational ALU with a registered {Z,N,C,V} flag vector.
// Define ALU_SLTU_EN to turn code 3'b011 into unsigned set-less-than.
module alu32
  import alu_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic [ALU_W-1:0] a,
  input  logic [ALU_W-1:0] b,
  input  logic [2:0]       alu_control,
  output logic [ALU_W-1:0] result,
  output logic [3:0]       flags
);

  alu_op_e          op;
  logic             sub_sel;
  logic [ALU_W-1:0] add_y;
  logic [ALU_W-1:0] add_sum;
  logic             add_cout;
  logic             add_ovf;
  logic [ALU_W-1:0] result_d;
  logic [3:0]       flags_d;
  logic [3:0]       flags_q;

  assign op = alu_op_e'(alu_control);

`ifdef ALU_SLTU_EN
  // SLTU sits at an encoding with bit 2 clear but still needs a - b.
  assign sub_sel = alu_control[2] | (op == ALU_SLTU);
`else
  assign sub_sel = alu_control[2];
`endif

  assign add_y = sub_sel ? ~b : b;

  alu_adder u_adder (
    .x    (a),
    .y    (add_y),
    .cin  (sub_sel),
    .sum  (add_sum),
    .cout (add_cout),
    .ovf  (add_ovf)
  );

  always_comb begin
    result_d = '0;
    case (op)
      ALU_AND:  result_d = a & b;
      ALU_OR:   result_d = a | b;
      ALU_ADD:  result_d = add_sum;
      ALU_ANDN: result_d = a & ~b;
      ALU_ORN:  result_d = a | ~b;
      ALU_SUB:  result_d = add_sum;
      ALU_SLT:  result_d = {{(ALU_W-1){1'b0}}, add_sum[ALU_W-1] ^ add_ovf};
`ifdef ALU_SLTU_EN
      // No carry-out from a + ~b + 1 means a borrow, i.e. a < b unsigned.
      ALU_SLTU: result_d = {{(ALU_W-1){1'b0}}, ~add_cout};
`endif
      default:  result_d = '0;
    endcase
  end

  always_comb begin
    flags_d        = '0;
    flags_d[FLG_Z] = (result_d == '0);
    flags_d[FLG_N] = result_d[ALU_W-1];
    if (is_arith(op)) begin
      flags_d[FLG_C] = add_cout;
      flags_d[FLG_V] = add_ovf;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      flags_q <= '0;
    end else begin
      flags_q <= flags_d;
    end
  end

  assign result = result_d;
  assign flags  = flags_q;

endmodule

// File: tb/tb_alu32.sv
// Directed and random checks of alu32 results and registered flags.
// Expected flags are queued at drive time and popped after the capturing edge.
module tb_alu32;

  logic        clk;
  logic        reset;
  logic [31:0] a;
  logic [31:0] b;
  logic [2:0]  alu_control;
  logic [31:0] result;
  logic [3:0]  flags;

  int n_cmp = 0;
  int n_bad = 0;
  logic [3:0] exp_q[$];

  alu32 dut (
    .clk         (clk),
    .reset       (reset),
    .a           (a),
    .b           (b),
    .alu_control (alu_control),
    .result      (result),
    .flags       (flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference behaviour written from the operation table: returns {flags, result}.
  function automatic logic [35:0] model(input logic [31:0] ma, input logic [31:0] mb,
                                        input logic [2:0] ctl);
    logic [31:0] r;
    logic        c;
    logic        v;
    longint      sa;
    longint      sb;
    longint      sr;
    sa = longint'($signed(ma));
    sb = longint'($signed(mb));
    r = 32'd0;
    c = 1'b0;
    v = 1'b0;
    case (ctl)
      3'b000: r = ma & mb;
      3'b001: r = ma | mb;
      3'b100: r = ma & ~mb;
      3'b101: r = ma | ~mb;
      3'b010: begin
        r  = ma + mb;
        c  = ({32'd0, ma} + {32'd0, mb}) > 64'hFFFF_FFFF;
        sr = sa + sb;
        v  = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      end
      3'b110, 3'b111: begin
        r  = (ctl == 3'b110) ? (ma - mb) : {31'd0, ($signed(ma) < $signed(mb))};
        c  = (ma >= mb);
        sr = sa - sb;
        v  = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      end
      default: begin
`ifdef ALU_SLTU_EN
        r  = {31'd0, (ma < mb)};
        c  = (ma >= mb);
        sr = sa - sb;
        v  = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
`else
        r  = 32'd0;
`endif
      end
    endcase
    model = {(r == 32'd0), r[31], c, v, r};
  endfunction

  task automatic run(input logic [31:0] ta, input logic [31:0] tb_v, input logic [2:0] ctl,
                     input logic [31:0] exp_r, input logic [3:0] exp_f, input string tag);
    @(negedge clk);
    a           = ta;
    b           = tb_v;
    alu_control = ctl;
    #1;
    check({tag, ".result"}, result, exp_r);
    exp_q.push_back(exp_f);
    @(posedge clk);
    #1;
    check({tag, ".flags"}, {28'd0, flags}, {28'd0, exp_q.pop_front()});
    $display("txn %-10s a=%h b=%h ctl=%b rst_n=%b result=%h flags=%b",
             tag, ta, tb_v, ctl, reset, result, flags);
  endtask

  initial begin
    logic [35:0] m;
    logic [31:0] ra;
    logic [31:0] rb;
    logic [2:0]  rc;

    reset       = 1'b0;
    a           = '0;
    b           = '0;
    alu_control = '0;

    // Reset held across an edge: flags clear while the result stays live.
    run(32'hFFFF_FFFF, 32'h1, 3'b010, 32'h0, 4'b0000, "rst_add");
    reset = 1'b1;
    run(32'hFFFF_FFFF, 32'h1, 3'b010, 32'h0, 4'b1010, "rel_add");

    run(32'h7FFF_FFFF, 32'h1, 3'b010, 32'h8000_0000, 4'b0101, "add_ovf");
    run(32'h5, 32'h5, 3'b110, 32'h0, 4'b1010, "sub_eq");
    run(32'h0, 32'h1, 3'b110, 32'hFFFF_FFFF, 4'b0100, "sub_brw");
    run(32'hF0F0_F0F0, 32'hFF00_FF00, 3'b000, 32'hF000_F000, 4'b0100, "and");
    run(32'hF0F0_F0F0, 32'hFF00_FF00, 3'b001, 32'hFFF0_FFF0, 4'b0100, "or");
    run(32'hF0F0_F0F0, 32'hFF00_FF00, 3'b100, 32'h00F0_00F0, 4'b0000, "andn");
    run(32'hF0F0_F0F0, 32'hFF00_FF00, 3'b101, 32'hF0FF_F0FF, 4'b0100, "orn");
    run(32'h8000_0000, 32'h1, 3'b111, 32'h1, 4'b0011, "slt_neg");
    run(32'h7FFF_FFFF, 32'h8000_0000, 3'b111, 32'h0, 4'b1001, "slt_ovf");
`ifdef ALU_SLTU_EN
    run(32'h1, 32'h2, 3'b011, 32'h1, 4'b0000, "sltu_lt");
    run(32'hFFFF_FFFF, 32'h1, 3'b011, 32'h0, 4'b1010, "sltu_ge");
`else
    run(32'h1, 32'h2, 3'b011, 32'h0, 4'b1000, "rsvd_a");
    run(32'hFFFF_FFFF, 32'h1, 3'b011, 32'h0, 4'b1000, "rsvd_b");
`endif

    // Reset in the middle of traffic, then recovery.
    reset = 1'b0;
    run(32'h0, 32'h1, 3'b110, 32'hFFFF_FFFF, 4'b0000, "rst_sub");
    reset = 1'b1;
    run(32'h0, 32'h1, 3'b110, 32'hFFFF_FFFF, 4'b0100, "rel_sub");

    for (int i = 0; i < 48; i++) begin
      ra = $urandom;
      rb = (i % 6 == 0) ? ra : $urandom;
      rc = 3'($urandom_range(0, 7));
      m  = model(ra, rb, rc);
      run(ra, rb, rc, m[31:0], m[35:32], "rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
